gain_button_ctrl: RTL and testbench
===================================

Name: gain_button_ctrl

Overview:
Upstream control stage for the noise generator's gain counter. Takes two raw, bouncing push-button inputs (gain up / gain down) and produces clean single-cycle `gain_inc` / `gain_dec` pulses in the `clk` domain. Each raw input goes through synchronisation, debounce, edge detection and hold-to-repeat. Pulses are mutually exclusive, and a both-pressed condition is locked out.

Parameters:
- BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed (board KEYs); 0 = active-high.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a new button level (10 ms at 50 MHz); must be >= 1.
- REPEAT_DELAY, 25000000, clk cycles a held button waits after its first pulse before the first repeat pulse; must be >= 1.
- REPEAT_RATE, 5000000, clk cycles between subsequent repeat pulses while held; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btn_up_raw  input  1  raw gain-up button, asynchronous to clk.
- btn_down_raw  input  1  raw gain-down button, asynchronous to clk.
- gain_inc  output  1  one-cycle pulse requesting gain +1.
- gain_dec  output  1  one-cycle pulse requesting gain -1.
- up_level  output  1  debounced gain-up level, 1 = pressed.
- down_level  output  1  debounced gain-down level, 1 = pressed.
- repeat_active  output  1  high while the FSM is generating auto-repeat pulses.

Behaviour:
- Reset (async assert, sync release by clk):
  - all outputs 0;
  - synchronisers at released level;
  - debounced levels 0;
  - all counters 0;
  - FSM in IDLE.
  - Reset mid-press aborts any pending or repeat pulse immediately.
- Synchroniser: 2-FF chain per button, then polarity normalisation so that 1 = pressed.
- Debounce (per button):
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
- Latency: a raw edge held stable produces the first pulse exactly DEBOUNCE_CYCLES+3 clk edges after the edge that first samples it (2 sync + DEBOUNCE_CYCLES + 1 output register).
- FSM states: IDLE, UP_HELD, DOWN_HELD, BOTH_LOCK.
  - IDLE: up rise with down_level=0 -> pulse gain_inc, load repeat counter with REPEAT_DELAY, go to UP_HELD. Down rise with up_level=0 is symmetric (gain_dec, DOWN_HELD). Both levels 1 in the same cycle -> BOTH_LOCK, no pulse.
  - UP_HELD / DOWN_HELD: counter decrements each cycle. On the cycle the counter reaches 0, emit one pulse for the held button, reload REPEAT_RATE and set repeat_active. Own button released -> IDLE, and repeat_active clears next cycle. Other button becomes pressed -> BOTH_LOCK with no pulse that cycle; release takes priority if both happen the same cycle.
  - BOTH_LOCK: no pulses. Stay until both debounced levels are 0, then go to IDLE. Releasing only one button does not resume repeat; both must be released.
- Invariants:
  - gain_inc & gain_dec is never 1.
  - Every pulse is exactly 1 cycle wide.
  - Outputs are registered.
- Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- A button held through reset release debounces to pressed afterwards and yields one normal press pulse.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, BTN_ACTIVE_LOW=1.
- Clean press: btn_up_raw 1->0 held 10 cycles, then released -> exactly one gain_inc pulse, 7 edges after the sampling edge; gain_dec stays 0; up_level high for the held duration.
- Bounce rejection: btn_down_raw toggles 0/1 every 2 cycles for 30 cycles, then returns to 1 -> no gain_dec pulse; down_level stays 0.
- Auto-repeat: btn_up_raw held 0 for 60 cycles after debounce -> pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52; repeat_active rises with the t0+20 pulse; no pulse after release.
- Both pressed: press up, then press down 5 cycles later while up is held -> one gain_inc pulse only, then no pulses. Release up only -> still none. Release down, then press down alone -> one gain_dec pulse.
- Reset mid-repeat: assert rst for 1 cycle during UP_HELD between repeat pulses -> all outputs 0 in the same cycle without waiting for a clk edge. With the button still held, exactly one gain_inc pulse follows DEBOUNCE_CYCLES+3 edges after rst release.
- Polarity: set BTN_ACTIVE_LOW=0 and drive btn_up_raw 0->1 -> identical pulse timing to the clean-press scenario.

Source files
------------

// File: rtl/gain_button_ctrl.sv
// Gain button front end: synchronises, debounces and edge-detects two raw push
// buttons and turns them into exclusive one-cycle gain_inc / gain_dec pulses with hold-to-repeat.
module gain_button_ctrl #(
   parameter int BTN_ACTIVE_LOW  = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic gain_inc,
   output logic gain_dec,
   output logic up_level,
   output logic down_level,
   output logic repeat_active
);

   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   localparam logic             BTN_REL  = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_RATE = RPT_W'(REPEAT_RATE);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_UP_HELD   = 2'd1;
   localparam logic [1:0] S_DOWN_HELD = 2'd2;
   localparam logic [1:0] S_BOTH_LOCK = 2'd3;

   logic             r_up_meta;
   logic             r_up_sync;
   logic             r_down_meta;
   logic             r_down_sync;
   logic [DEB_W-1:0] r_up_cnt;
   logic [DEB_W-1:0] r_down_cnt;
   logic             r_up_prev;
   logic             r_down_prev;
   logic [1:0]       r_state;
   logic [RPT_W-1:0] r_rpt_cnt;

   logic             w_up_pressed;
   logic             w_down_pressed;
   logic             w_up_rise;
   logic             w_down_rise;
   logic [1:0]       w_state_nxt;
   logic [RPT_W-1:0] w_rpt_cnt_nxt;
   logic             w_inc_nxt;
   logic             w_dec_nxt;
   logic             w_rpt_nxt;

   // Synchronisers reset to the released level so reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_up_meta   <= BTN_REL;
         r_up_sync   <= BTN_REL;
         r_down_meta <= BTN_REL;
         r_down_sync <= BTN_REL;
      end else begin
         r_up_meta   <= btn_up_raw;
         r_up_sync   <= r_up_meta;
         r_down_meta <= btn_down_raw;
         r_down_sync <= r_down_meta;
      end
   end

   assign w_up_pressed   = r_up_sync ^ BTN_REL;
   assign w_down_pressed = r_down_sync ^ BTN_REL;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_up_cnt <= '0;
         up_level <= 1'b0;
      end else if (w_up_pressed == up_level) begin
         r_up_cnt <= '0;
      end else if (r_up_cnt == DEB_LAST) begin
         up_level <= w_up_pressed;
         r_up_cnt <= '0;
      end else begin
         r_up_cnt <= r_up_cnt + DEB_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_down_cnt <= '0;
         down_level <= 1'b0;
      end else if (w_down_pressed == down_level) begin
         r_down_cnt <= '0;
      end else if (r_down_cnt == DEB_LAST) begin
         down_level <= w_down_pressed;
         r_down_cnt <= '0;
      end else begin
         r_down_cnt <= r_down_cnt + DEB_W'(1);
      end
   end

   assign w_up_rise   = up_level & ~r_up_prev;
   assign w_down_rise = down_level & ~r_down_prev;

   // Release beats a second press, which beats a repeat pulse due in the same cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_rpt_cnt_nxt = r_rpt_cnt;
      w_inc_nxt     = 1'b0;
      w_dec_nxt     = 1'b0;
      w_rpt_nxt     = repeat_active;
      case (r_state)
         S_IDLE: begin
            w_rpt_nxt = 1'b0;
            if (up_level && down_level) begin
               w_state_nxt = S_BOTH_LOCK;
            end else if (w_up_rise) begin
               w_inc_nxt     = 1'b1;
               w_rpt_cnt_nxt = RPT_DLY;
               w_state_nxt   = S_UP_HELD;
            end else if (w_down_rise) begin
               w_dec_nxt     = 1'b1;
               w_rpt_cnt_nxt = RPT_DLY;
               w_state_nxt   = S_DOWN_HELD;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_UP_HELD: begin
            if (!up_level) begin
               w_state_nxt = S_IDLE;
               w_rpt_nxt   = 1'b0;
            end else if (down_level) begin
               w_state_nxt = S_BOTH_LOCK;
               w_rpt_nxt   = 1'b0;
            end else if (r_rpt_cnt <= RPT_W'(1)) begin
               w_inc_nxt     = 1'b1;
               w_rpt_cnt_nxt = RPT_RATE;
               w_rpt_nxt     = 1'b1;
            end else begin
               w_rpt_cnt_nxt = r_rpt_cnt - RPT_W'(1);
            end
         end
         S_DOWN_HELD: begin
            if (!down_level) begin
               w_state_nxt = S_IDLE;
               w_rpt_nxt   = 1'b0;
            end else if (up_level) begin
               w_state_nxt = S_BOTH_LOCK;
               w_rpt_nxt   = 1'b0;
            end else if (r_rpt_cnt <= RPT_W'(1)) begin
               w_dec_nxt     = 1'b1;
               w_rpt_cnt_nxt = RPT_RATE;
               w_rpt_nxt     = 1'b1;
            end else begin
               w_rpt_cnt_nxt = r_rpt_cnt - RPT_W'(1);
            end
         end
         S_BOTH_LOCK: begin
            w_rpt_nxt = 1'b0;
            if (!up_level && !down_level) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_BOTH_LOCK;
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_rpt_cnt_nxt = '0;
            w_rpt_nxt     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_rpt_cnt     <= '0;
         r_up_prev     <= 1'b0;
         r_down_prev   <= 1'b0;
         gain_inc      <= 1'b0;
         gain_dec      <= 1'b0;
         repeat_active <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_rpt_cnt     <= w_rpt_cnt_nxt;
         r_up_prev     <= up_level;
         r_down_prev   <= down_level;
         gain_inc      <= w_inc_nxt;
         gain_dec      <= w_dec_nxt;
         repeat_active <= w_rpt_nxt;
      end
   end

endmodule

// File: tb/tb_gain_button_ctrl.sv
// Directed bench for gain_button_ctrl: vector table for press/bounce timing plus
// hand-written sequences for repeat, lockout, reset and polarity.
module tb_gain_button_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic up_raw, down_raw;
   logic inc, dec, ul, dl, rpt;
   logic ah_up_raw, ah_down_raw;
   logic ah_inc, ah_dec, ah_ul, ah_dl, ah_rpt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic up_raw;
      logic down_raw;
      int   cycles;
      logic e_inc;
      logic e_dec;
      logic e_ul;
      logic e_dl;
      logic e_rpt;
   } seg_t;

   seg_t segs[$];

   gain_button_ctrl #(
      .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)
   ) dut (
      .clk(clk), .rst(rst), .btn_up_raw(up_raw), .btn_down_raw(down_raw),
      .gain_inc(inc), .gain_dec(dec), .up_level(ul), .down_level(dl),
      .repeat_active(rpt)
   );

   gain_button_ctrl #(
      .BTN_ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)
   ) dut_ah (
      .clk(clk), .rst(rst), .btn_up_raw(ah_up_raw), .btn_down_raw(ah_down_raw),
      .gain_inc(ah_inc), .gain_dec(ah_dec), .up_level(ah_ul), .down_level(ah_dl),
      .repeat_active(ah_rpt)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_inc, input logic e_dec,
                          input logic e_ul, input logic e_dl, input logic e_rpt);
      chk({tag, " gain_inc"}, inc, e_inc);
      chk({tag, " gain_dec"}, dec, e_dec);
      chk({tag, " up_level"}, ul, e_ul);
      chk({tag, " down_level"}, dl, e_dl);
      chk({tag, " repeat_active"}, rpt, e_rpt);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_no_pulse(input string tag, input int n);
      for (int c = 1; c <= n; c++) begin
         tick();
         chk($sformatf("%s c%0d gain_inc", tag, c), inc, 1'b0);
         chk($sformatf("%s c%0d gain_dec", tag, c), dec, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1;
      up_raw = 1'b1; down_raw = 1'b1;
      ah_up_raw = 1'b0; ah_down_raw = 1'b0;
      tick(); tick();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset ah gain_inc", ah_inc, 1'b0);
      chk("reset ah up_level", ah_ul, 1'b0);
      rst = 1'b0;
      tick(); tick();
      chk_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Clean press: level at edge 6, single pulse at edge 7, level drops 5 edges after release.
      segs.push_back('{1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      segs.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      segs.push_back('{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      segs.push_back('{1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      segs.push_back('{1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      segs.push_back('{1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      for (int k = 0; k < 15; k++) begin
         segs.push_back('{1'b1, ((k % 2) == 0) ? 1'b0 : 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      end
      segs.push_back('{1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

      foreach (segs[s]) begin
         up_raw   = segs[s].up_raw;
         down_raw = segs[s].down_raw;
         for (int k = 0; k < segs[s].cycles; k++) begin
            tick();
            chk_all($sformatf("vec%0d.%0d", s, k), segs[s].e_inc, segs[s].e_dec,
                    segs[s].e_ul, segs[s].e_dl, segs[s].e_rpt);
         end
      end

      // Auto-repeat: release driven after cycle 58 stops repeats before cycle 67.
      up_raw = 1'b0;
      for (int c = 1; c <= 90; c++) begin
         tick();
         chk($sformatf("rep c%0d gain_inc", c), inc,
             (c == 7 || c == 27 || c == 35 || c == 43 || c == 51 || c == 59) ? 1'b1 : 1'b0);
         chk($sformatf("rep c%0d gain_dec", c), dec, 1'b0);
         chk($sformatf("rep c%0d repeat_active", c), rpt, (c >= 27 && c <= 64) ? 1'b1 : 1'b0);
         if (c == 58) up_raw = 1'b1;
      end

      // Both pressed: one inc, then lockout until both are released.
      up_raw = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         chk($sformatf("both c%0d gain_inc", c), inc, (c == 7) ? 1'b1 : 1'b0);
         chk($sformatf("both c%0d gain_dec", c), dec, 1'b0);
         if (c == 5) down_raw = 1'b0;
      end
      chk("both levels up", ul, 1'b1);
      chk("both levels down", dl, 1'b1);
      chk("both repeat_active", rpt, 1'b0);
      up_raw = 1'b1;
      idle_no_pulse("both_relup", 20);
      chk("relup up_level", ul, 1'b0);
      chk("relup down_level", dl, 1'b1);
      down_raw = 1'b1;
      idle_no_pulse("both_reldn", 20);
      chk("reldn down_level", dl, 1'b0);
      down_raw = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk($sformatf("dn c%0d gain_dec", c), dec, (c == 7) ? 1'b1 : 1'b0);
         chk($sformatf("dn c%0d gain_inc", c), inc, 1'b0);
      end
      down_raw = 1'b1;
      idle_no_pulse("dn_rel", 20);

      // Reset between repeat pulses, button kept held.
      up_raw = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         chk($sformatf("prerst c%0d gain_inc", c), inc, (c == 7 || c == 27) ? 1'b1 : 1'b0);
      end
      chk("prerst repeat_active", rpt, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk($sformatf("postrst c%0d gain_inc", c), inc, (c == 7) ? 1'b1 : 1'b0);
         chk($sformatf("postrst c%0d up_level", c), ul, (c >= 6) ? 1'b1 : 1'b0);
         chk($sformatf("postrst c%0d repeat_active", c), rpt, 1'b0);
      end
      up_raw = 1'b1;
      idle_no_pulse("postrst_rel", 20);

      // Active-high instance: same timing as the clean press.
      ah_up_raw = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk($sformatf("ah c%0d gain_inc", c), ah_inc, (c == 7) ? 1'b1 : 1'b0);
         chk($sformatf("ah c%0d up_level", c), ah_ul, (c >= 6) ? 1'b1 : 1'b0);
         chk($sformatf("ah c%0d gain_dec", c), ah_dec, 1'b0);
      end
      ah_up_raw = 1'b0;
      for (int c = 1; c <= 12; c++) tick();
      chk("ah released up_level", ah_ul, 1'b0);
      chk("ah released repeat_active", ah_rpt, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
